// File: rtl/conv_ser_pkg.sv
// Shared types and constants for the serializer gearbox: FSM states and line-pair encodings.
package conv_ser_pkg;

    typedef logic [1:0] pair_t;

    typedef enum logic {
        S_IDLE,
        S_DATA
    } state_t;

    localparam pair_t IDLE_PAIR = 2'b10;
    localparam pair_t HDR_PAIR  = 2'b01;

endpackage

// File: rtl/conv_ser_fifo.sv
// Small synchronous word FIFO with a registered ready flag and a show-ahead head word.
module conv_ser_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     ready_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      level_q;
    logic [AW:0]      level_d;
    logic             ready_q;
    logic             doPush;
    logic             doPop;

    // Pushes are gated by the registered ready, so a full FIFO never accepts a word even when it pops.
    assign doPush = push_i && ready_q;
    assign doPop  = pop_i && (level_q != '0);

    always_comb begin
        level_d = level_q;
        if (doPush && !doPop) begin
            level_d = level_q + 1'b1;
        end else if (!doPush && doPop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
            ready_q <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            level_q <= level_d;
            ready_q <= (level_d != FULL_LVL);
        end
    end

    always_ff @(posedge CLK) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rdPtr_q];
    assign ready_o = ready_q;
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/conv_ser_gearbox.sv
// Frames buffered words as header + MSB-first bit pairs, one pair per clock, for the 2:1 DDR serializer.
module conv_ser_gearbox
    import conv_ser_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [WORD_W-1:0]             IN_DATA,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    output logic                          PAR_OUT1,
    output logic                          PAR_OUT2,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic [CNT_W-1:0]              FRAMES_SENT
);

    localparam int NPAIRS = WORD_W / 2;
    localparam int PCW    = $clog2(NPAIRS + 2);
    localparam logic [PCW-1:0] PAIRS_INIT  = PCW'(NPAIRS);
    localparam logic [PCW-1:0] HDR_PENDING = PCW'(NPAIRS + 1);
    localparam logic [PCW-1:0] LAST_PAIR   = PCW'(1);

    state_t            state_q;
    logic [WORD_W-1:0] shreg_q;
    logic [PCW-1:0]    pairCnt_q;
    pair_t             pair_q;
    logic              busy_q;
    logic [CNT_W-1:0]  framesSent_q;

    logic              fifoPop;
    logic              fifoEmpty;
    logic [WORD_W-1:0] fifoHead;

    conv_ser_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push_i  (IN_VALID),
        .pop_i   (fifoPop),
        .wdata_i (IN_DATA),
        .rdata_o (fifoHead),
        .ready_o (IN_READY),
        .empty_o (fifoEmpty),
        .level_o (FIFO_LEVEL)
    );

    assign fifoPop = !fifoEmpty &&
                     ((state_q == S_IDLE) || ((state_q == S_DATA) && (pairCnt_q == LAST_PAIR)));

    // A word popped on a frame's last pair parks the counter at HDR_PENDING so its header follows with no idle gap.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            pairCnt_q    <= '0;
            pair_q       <= IDLE_PAIR;
            busy_q       <= 1'b0;
            framesSent_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifoEmpty) begin
                        shreg_q   <= fifoHead;
                        pairCnt_q <= PAIRS_INIT;
                        pair_q    <= HDR_PAIR;
                        busy_q    <= 1'b1;
                        state_q   <= S_DATA;
                    end else begin
                        pair_q <= IDLE_PAIR;
                        busy_q <= 1'b0;
                    end
                end
                S_DATA: begin
                    busy_q <= 1'b1;
                    if (pairCnt_q == HDR_PENDING) begin
                        pair_q    <= HDR_PAIR;
                        pairCnt_q <= PAIRS_INIT;
                    end else begin
                        pair_q    <= shreg_q[WORD_W-1 -: 2];
                        shreg_q   <= shreg_q << 2;
                        pairCnt_q <= pairCnt_q - 1'b1;
                        if (pairCnt_q == LAST_PAIR) begin
                            framesSent_q <= framesSent_q + 1'b1;
                            if (!fifoEmpty) begin
                                shreg_q   <= fifoHead;
                                pairCnt_q <= HDR_PENDING;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign PAR_OUT1    = pair_q[1];
    assign PAR_OUT2    = pair_q[0];
    assign BUSY        = busy_q;
    assign FRAMES_SENT = framesSent_q;

endmodule

// File: tb/tb_conv_ser_gearbox.sv
// Directed bench for conv_ser_gearbox; CNT_W=2 so the frame counter wraps within the short tests.
module tb_conv_ser_gearbox;

    logic        CLK;
    logic        RESET;
    logic [15:0] IN_DATA;
    logic        IN_VALID;
    logic        IN_READY;
    logic        PAR_OUT1;
    logic        PAR_OUT2;
    logic        BUSY;
    logic [2:0]  FIFO_LEVEL;
    logic [1:0]  FRAMES_SENT;

    int passCount;
    int checkCount;

    logic [1:0]  a5Pairs [8] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b11};
    logic [15:0] bpWords [6] = '{16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hC3A5};
    logic [15:0] wrapWords [5] = '{16'h0001, 16'h8000, 16'h5A5A, 16'hF00F, 16'h3C3C};
    logic [1:0]  wrapExp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [1:0]  expPair [$];
    logic        expBusy [$];

    conv_ser_gearbox #(
        .WORD_W     (16),
        .FIFO_DEPTH (4),
        .CNT_W      (2)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IN_DATA     (IN_DATA),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .PAR_OUT1    (PAR_OUT1),
        .PAR_OUT2    (PAR_OUT2),
        .BUSY        (BUSY),
        .FIFO_LEVEL  (FIFO_LEVEL),
        .FRAMES_SENT (FRAMES_SENT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        RESET    = 1'b1;
        IN_VALID = 1'b0;
        tick();
        RESET = 1'b0;
        tick();
    endtask

    // One push into an idle, empty block; the header is not yet visible after the push edge.
    task automatic applyStimulus(input logic [15:0] word);
        IN_DATA  = word;
        IN_VALID = 1'b1;
        checkOutput("sendReady", 32'(IN_READY), 32'd1);
        tick();
        IN_VALID = 1'b0;
        checkOutput("sendLevel", 32'(FIFO_LEVEL), 32'd1);
        checkOutput("sendPairIdle", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b10));
    endtask

    task automatic checkFrame(input string tag, input logic [15:0] word, input logic [1:0] frames);
        tick();
        checkOutput({tag, "Hdr"}, 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b01));
        checkOutput({tag, "HdrBusy"}, 32'(BUSY), 32'd1);
        for (int j = 0; j < 8; j++) begin
            tick();
            checkOutput({tag, "Pair"}, 32'({PAR_OUT1, PAR_OUT2}), 32'(word[15-2*j -: 2]));
            checkOutput({tag, "Busy"}, 32'(BUSY), 32'd1);
        end
        checkOutput({tag, "Frames"}, 32'(FRAMES_SENT), 32'(frames));
    endtask

    initial begin
        int  wIdx;
        bit  willPush;
        bit  sawFull;
        passCount  = 0;
        checkCount = 0;
        RESET      = 1'b1;
        IN_VALID   = 1'b0;
        IN_DATA    = '0;

        // Reset held three cycles, then ten idle cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rstPair", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b10));
            checkOutput("rstBusy", 32'(BUSY), 32'd0);
            checkOutput("rstReady", 32'(IN_READY), 32'd0);
            checkOutput("rstLevel", 32'(FIFO_LEVEL), 32'd0);
            checkOutput("rstFrames", 32'(FRAMES_SENT), 32'd0);
        end
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("idlePair", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b10));
            checkOutput("idleBusy", 32'(BUSY), 32'd0);
            checkOutput("idleReady", 32'(IN_READY), 32'd1);
            checkOutput("idleFrames", 32'(FRAMES_SENT), 32'd0);
        end

        // Single word A5C3 with hand-listed pairs.
        doReset();
        applyStimulus(16'hA5C3);
        tick();
        checkOutput("a5Hdr", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b01));
        checkOutput("a5HdrBusy", 32'(BUSY), 32'd1);
        checkOutput("a5Level", 32'(FIFO_LEVEL), 32'd0);
        for (int j = 0; j < 8; j++) begin
            tick();
            checkOutput("a5Pair", 32'({PAR_OUT1, PAR_OUT2}), 32'(a5Pairs[j]));
            checkOutput("a5Busy", 32'(BUSY), 32'd1);
        end
        checkOutput("a5Frames", 32'(FRAMES_SENT), 32'd1);
        tick();
        checkOutput("a5IdlePair", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b10));
        checkOutput("a5IdleBusy", 32'(BUSY), 32'd0);

        // Back-to-back FFFF then 0000.
        doReset();
        IN_DATA  = 16'hFFFF;
        IN_VALID = 1'b1;
        tick();
        IN_DATA = 16'h0000;
        tick();
        IN_VALID = 1'b0;
        checkOutput("b2bHdr1", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b01));
        for (int j = 0; j < 8; j++) begin
            tick();
            checkOutput("b2bOnes", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b11));
        end
        checkOutput("b2bFrames1", 32'(FRAMES_SENT), 32'd1);
        tick();
        checkOutput("b2bHdr2", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b01));
        checkOutput("b2bHdr2Busy", 32'(BUSY), 32'd1);
        for (int j = 0; j < 8; j++) begin
            tick();
            checkOutput("b2bZeros", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b00));
        end
        checkOutput("b2bFrames2", 32'(FRAMES_SENT), 32'd2);
        tick();
        checkOutput("b2bIdle", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b10));
        checkOutput("b2bIdleBusy", 32'(BUSY), 32'd0);

        // Backpressure: six words offered continuously into a four-deep FIFO.
        doReset();
        expPair.delete();
        expBusy.delete();
        expPair.push_back(2'b10);
        expBusy.push_back(1'b0);
        for (int w = 0; w < 6; w++) begin
            expPair.push_back(2'b01);
            expBusy.push_back(1'b1);
            for (int j = 0; j < 8; j++) begin
                expPair.push_back(bpWords[w][15-2*j -: 2]);
                expBusy.push_back(1'b1);
            end
        end
        expPair.push_back(2'b10);
        expBusy.push_back(1'b0);
        wIdx     = 0;
        sawFull  = 0;
        IN_DATA  = bpWords[0];
        IN_VALID = 1'b1;
        for (int c = 0; c < 56; c++) begin
            willPush = IN_VALID && IN_READY;
            tick();
            if (willPush) wIdx++;
            if (wIdx < 6) begin
                IN_VALID = 1'b1;
                IN_DATA  = bpWords[wIdx];
            end else begin
                IN_VALID = 1'b0;
            end
            checkOutput("bpPair", 32'({PAR_OUT1, PAR_OUT2}), 32'(expPair[c]));
            checkOutput("bpBusy", 32'(BUSY), 32'(expBusy[c]));
            checkOutput("bpReady", 32'(IN_READY), 32'(FIFO_LEVEL != 3'd4));
            if (FIFO_LEVEL == 3'd4) sawFull = 1;
        end
        checkOutput("bpPushed", 32'(wIdx), 32'd6);
        checkOutput("bpSawFull", 32'(sawFull), 32'd1);
        checkOutput("bpFrames", 32'(FRAMES_SENT), 32'd2);
        checkOutput("bpLevelEnd", 32'(FIFO_LEVEL), 32'd0);

        // Reset after the third data pair of 1234 with two words queued.
        doReset();
        IN_DATA  = 16'h1234;
        IN_VALID = 1'b1;
        tick();
        IN_DATA = 16'hAAAA;
        tick();
        checkOutput("mrHdr", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b01));
        IN_DATA = 16'h5555;
        tick();
        IN_VALID = 1'b0;
        checkOutput("mrPair1", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b00));
        checkOutput("mrQueued", 32'(FIFO_LEVEL), 32'd2);
        tick();
        checkOutput("mrPair2", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b01));
        tick();
        checkOutput("mrPair3", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b00));
        RESET = 1'b1;
        tick();
        checkOutput("mrRstPair", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b10));
        checkOutput("mrRstBusy", 32'(BUSY), 32'd0);
        checkOutput("mrRstLevel", 32'(FIFO_LEVEL), 32'd0);
        checkOutput("mrRstFrames", 32'(FRAMES_SENT), 32'd0);
        checkOutput("mrRstReady", 32'(IN_READY), 32'd0);
        RESET = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("mrAfterPair", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b10));
            checkOutput("mrAfterBusy", 32'(BUSY), 32'd0);
            checkOutput("mrAfterFrames", 32'(FRAMES_SENT), 32'd0);
        end

        // Counter wrap with a two-bit frame counter.
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(wrapWords[i]);
            checkFrame("wrap", wrapWords[i], wrapExp[i]);
            tick();
            checkOutput("wrapIdle", 32'({PAR_OUT1, PAR_OUT2}), 32'(2'b10));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
